ps2_arrow_decoder: RTL
======================

Name: ps2_arrow_decoder

Overview:
- Receives the raw PS/2 keyboard serial stream and converts it into the level signals that the player and game control blocks consume: leftArrowPressed, rightArrowPressed, upArrowPressed, downArrowPressed and enterPressed.
- Sits between the board PS/2 pins and the player top level.
- Does frame deserialization, parity checking and scan-code set 2 make/break decoding, including the E0 extended prefix.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used only to derive the frame timeout.
- TIMEOUT_US, 200, maximum gap between ps2_clk falling edges inside one frame before the frame is abandoned.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous reset, active-high. Sampled on the clk rising edge.
- ps2_clk  in  1  raw keyboard clock, asynchronous to clk.
- ps2_data  in  1  raw keyboard data, asynchronous to clk.
- leftArrowPressed  out  1  high while Left arrow (E0 6B) is held.
- rightArrowPressed  out  1  high while Right arrow (E0 74) is held.
- upArrowPressed  out  1  high while Up arrow (E0 75) is held.
- downArrowPressed  out  1  high while Down arrow (E0 72) is held.
- enterPressed  out  1  high while Enter (5A, non-extended) is held.
- key_event  out  1  one-clk pulse whenever any of the five levels changes.
- frame_error  out  1  one-clk pulse on a parity, start or stop error, or on a timeout.

Behaviour:
- Reset (resetN=1 at a clk edge) clears all outputs, both synchronizers, the bit counter, the shift register, the timeout counter and the FSM (state returns to IDLE). A reset mid-frame discards the partial frame.
- Input sync: ps2_clk and ps2_data each pass through 2 flip-flops.
- Edge detect: a falling edge is registered sync_clk_d=1 with sync_clk=0.
  - ps2_data is sampled on that same clk cycle.
  - Latency from a pin edge to its detection: 3 clk.
- Frame format: 11 bits = start(0), D0..D7 (LSB first), odd parity, stop(1).
- Bit counter (4 bits) counts 0..10 and increments once per falling edge. The frame is evaluated on the cycle that samples bit 10.
- Frame validity: start==0, stop==1 and the XOR of D0..D7 and parity ==1.
  - Valid frame: byte handed to the scan FSM in the same cycle.
  - Invalid frame: byte dropped, frame_error pulse, FSM forced to IDLE.
  - In both cases the bit counter returns to 0.
- Timeout: a counter of width ceil(log2(CLK_HZ/1e6*TIMEOUT_US+1)) runs while the bit counter is nonzero and clears on each falling edge.
  - On reaching CLK_HZ/1000000*TIMEOUT_US: bit counter returns to 0, frame_error pulses, FSM returns to IDLE.
  - The counter is idle while the bit counter is 0.
- Scan FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on each valid byte:
  - IDLE: E0 -> EXT; F0 -> BRK; 5A -> set enter, back to IDLE; anything else -> IDLE, ignored.
  - EXT: F0 -> EXT_BRK; 6B/74/75/72 -> set the matching arrow, then IDLE; other -> IDLE.
  - BRK: 5A -> clear enter; any byte -> IDLE.
  - EXT_BRK: 6B/74/75/72 -> clear the matching arrow; any byte -> IDLE.
- Typematic repeats (the same make code again) are allowed: the level stays 1 and no key_event is raised.
- Non-extended 6B/74/75/72 (keypad 4/6/8/2) never affect the arrows.
- Outputs are registered. A level updates 1 clk after the valid stop bit is sampled. key_event is asserted in that same cycle only if the level actually changed.
- Opposite arrows may be high at the same time. They are passed through unfiltered; the player block resolves them.
- Glitch immunity: ps2_data changes while ps2_clk is high have no effect.

Test Plan:
- Reset, then send E0 then 6B with correct parity -> leftArrowPressed=1 and one key_event pulse 1 clk after the second stop bit; the other outputs stay 0.
- Send E0 F0 6B after the left press -> leftArrowPressed=0 and a single key_event pulse; send E0 6B twice -> level stays 1 and key_event pulses only once.
- Send 74 without E0 -> no output change, FSM back in IDLE; then send E0 74 -> rightArrowPressed=1.
- Send 5A with a flipped parity bit -> frame_error pulses once, enterPressed stays 0; the next good 5A frame -> enterPressed=1.
- Stop after 5 bits for more than 200 us (10000 clk at 50 MHz) -> frame_error pulses; a complete E0 75 frame pair afterwards -> upArrowPressed=1.
- Hold downArrow (E0 72), then assert resetN for 1 clk in the middle of the next frame -> all outputs 0 immediately after that edge, and the partial frame is ignored.

Source files
------------

// File: rtl/ps2_arrow_decoder.sv
// rtl/ps2_arrow_decoder.sv - PS/2 set-2 frame receiver and arrow/enter key level decoder
module ps2_arrow_decoder #(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 200
) (
  input  logic clk,
  input  logic resetN,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic leftArrowPressed,
  output logic rightArrowPressed,
  output logic upArrowPressed,
  output logic downArrowPressed,
  output logic enterPressed,
  output logic key_event,
  output logic frame_error
);

  localparam int TO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Level vector order: {left, right, up, down, enter}
  localparam logic [4:0] ENTER_BIT = 5'b00001;

  logic [2:0]      clk_sync_q;   // [1] = sync_clk, [2] = sync_clk_d
  logic [1:0]      data_sync_q;
  logic [3:0]      bit_cnt_q;
  logic [9:0]      sr_q;         // start, D0..D7, parity once 10 bits are in
  logic [TO_W-1:0] to_cnt_q;
  state_t          state_q, state_d;
  logic [4:0]      lvl_q, lvl_d;
  logic            key_event_q, key_event_d;
  logic            frame_error_q, frame_error_d;

  logic       fall;
  logic       sample_bit;
  logic       last_bit;
  logic       frame_ok;
  logic       frame_bad;
  logic       timeout;
  logic [7:0] rx_byte;

  function automatic logic [4:0] arrow_mask(input logic [7:0] code);
    case (code)
      8'h6B:   arrow_mask = 5'b10000;
      8'h74:   arrow_mask = 5'b01000;
      8'h75:   arrow_mask = 5'b00100;
      8'h72:   arrow_mask = 5'b00010;
      default: arrow_mask = 5'b00000;
    endcase
  endfunction

  assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
  assign sample_bit = data_sync_q[1];
  assign last_bit   = fall && (bit_cnt_q == 4'd10);
  assign rx_byte    = sr_q[8:1];
  // Odd parity: XOR over the data bits and the parity bit must be 1.
  assign frame_ok   = last_bit && !sr_q[0] && sample_bit && (^sr_q[9:1]);
  assign frame_bad  = last_bit && !frame_ok;
  // A falling edge in the same cycle wins over the timeout.
  assign timeout    = (to_cnt_q == TO_W'(TO_LIMIT)) && !fall;

  // Two-flop synchronizers plus one delay stage on the clock for edge detection.
  always_ff @(posedge clk) begin
    if (resetN) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // Bit counter, LSB-first shift register and inter-edge timeout counter.
  always_ff @(posedge clk) begin
    if (resetN) begin
      bit_cnt_q <= '0;
      sr_q      <= '0;
      to_cnt_q  <= '0;
    end else if (fall) begin
      to_cnt_q <= '0;
      if (last_bit) begin
        bit_cnt_q <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
        sr_q      <= {sample_bit, sr_q[9:1]};
      end
    end else if (timeout) begin
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else if (bit_cnt_q != 4'd0) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Scan FSM and output registers.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q       <= IDLE;
      lvl_q         <= '0;
      key_event_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lvl_q         <= lvl_d;
      key_event_q   <= key_event_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next state: make/break decoding with E0 prefix; errors drop back to IDLE.
  always_comb begin
    state_d       = state_q;
    lvl_d         = lvl_q;
    frame_error_d = frame_bad || timeout;
    if (frame_bad || timeout) begin
      state_d = IDLE;
    end else if (frame_ok) begin
      state_d = IDLE;
      case (state_q)
        IDLE: begin
          if (rx_byte == 8'hE0)      state_d = EXT;
          else if (rx_byte == 8'hF0) state_d = BRK;
          else if (rx_byte == 8'h5A) lvl_d   = lvl_q | ENTER_BIT;
        end
        EXT: begin
          if (rx_byte == 8'hF0) state_d = EXT_BRK;
          else                  lvl_d   = lvl_q | arrow_mask(rx_byte);
        end
        BRK: begin
          if (rx_byte == 8'h5A) lvl_d = lvl_q & ~ENTER_BIT;
        end
        EXT_BRK: begin
          lvl_d = lvl_q & ~arrow_mask(rx_byte);
        end
        default: state_d = IDLE;
      endcase
    end
    key_event_d = (lvl_d != lvl_q);
  end

  assign leftArrowPressed  = lvl_q[4];
  assign rightArrowPressed = lvl_q[3];
  assign upArrowPressed    = lvl_q[2];
  assign downArrowPressed  = lvl_q[1];
  assign enterPressed      = lvl_q[0];
  assign key_event         = key_event_q;
  assign frame_error       = frame_error_q;

endmodule
